// File: rtl/alu_arb_pkg.sv
// Shared constants, FSM encoding and helpers for the ALU issue arbiter.
package alu_arb_pkg;
  localparam int DATA_W  = 16;
  localparam int CTRL_W  = 3;
  localparam int MAX_REQ = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } arb_state_t;

  // Binary index of the set bit of a one-hot vector (highest set bit wins otherwise).
  function automatic logic [2:0] onehot_to_idx(input logic [MAX_REQ-1:0] oh);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 0; i < MAX_REQ; i++)
      if (oh[i]) idx = 3'(i);
    return idx;
  endfunction
endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first request at or above ptr, wrapping.
module rr_arbiter
  import alu_arb_pkg::*;
#(
  parameter int NREQ  = 2,
  parameter int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] ptr,
  input  logic             enable,
  output logic [NREQ-1:0]  grant,
  output logic [IDX_W-1:0] idx
);
  logic [MAX_REQ-1:0] grant_pad;

  always_comb begin
    logic found;
    int   cand;
    grant = '0;
    found = 1'b0;
    cand  = 0;
    for (int k = 0; k < NREQ; k++) begin
      cand = int'(ptr) + k;
      if (cand >= NREQ) cand = cand - NREQ;
      for (int i = 0; i < NREQ; i++) begin
        if (enable && !found && req[i] && (i == cand)) begin
          grant[i] = 1'b1;
          found    = 1'b1;
        end
      end
    end
  end

  for (genvar gi = 0; gi < MAX_REQ; gi++) begin : g_pad
    if (gi < NREQ) begin : g_live
      assign grant_pad[gi] = grant[gi];
    end else begin : g_tie
      assign grant_pad[gi] = 1'b0;
    end
  end

  assign idx = IDX_W'(onehot_to_idx(grant_pad));
endmodule

// File: rtl/alu_issue_arbiter.sv
// Shares one ALU between NREQ valid/ready requesters, round-robin, one op in flight.
module alu_issue_arbiter
  import alu_arb_pkg::*;
#(
  parameter int NREQ    = 2,
  parameter int DATA_W  = alu_arb_pkg::DATA_W,
  parameter int CTRL_W  = alu_arb_pkg::CTRL_W,
  parameter int ALU_LAT = 1,
  parameter int CNT_W   = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NREQ-1:0]          req_valid,
  output logic [NREQ-1:0]          req_ready,
  input  logic [NREQ*DATA_W-1:0]   req_a,
  input  logic [NREQ*DATA_W-1:0]   req_b,
  input  logic [NREQ*CTRL_W-1:0]   req_ctrl,
  output logic [NREQ-1:0]          rsp_valid,
  input  logic [NREQ-1:0]          rsp_ready,
  output logic [DATA_W-1:0]        rsp_r,
  output logic                     rsp_zero,
  output logic [DATA_W-1:0]        alu_a,
  output logic [DATA_W-1:0]        alu_b,
  output logic [CTRL_W-1:0]        alu_ctrl,
  input  logic [DATA_W-1:0]        alu_r,
  input  logic                     alu_zero,
  output logic                     busy,
  output logic [CNT_W-1:0]         ops_done
);
  localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int LAT_W = (ALU_LAT > 0) ? $clog2(ALU_LAT + 1) : 1;

  arb_state_t        state_reg;
  logic [IDX_W-1:0]  ptr_reg;
  logic [IDX_W-1:0]  owner_reg;
  logic [LAT_W-1:0]  lat_cnt_reg;
  logic [NREQ-1:0]   rsp_valid_reg;
  logic [DATA_W-1:0] rsp_r_reg;
  logic              rsp_zero_reg;
  logic [DATA_W-1:0] alu_a_reg;
  logic [DATA_W-1:0] alu_b_reg;
  logic [CTRL_W-1:0] alu_ctrl_reg;
  logic [CNT_W-1:0]  ops_done_reg;

  logic [NREQ-1:0]   grant;
  logic [IDX_W-1:0]  grant_idx;
  logic              arb_enable;
  logic              accept;
  logic              rsp_fire;

  logic [DATA_W-1:0] a_slice [NREQ];
  logic [DATA_W-1:0] b_slice [NREQ];
  logic [CTRL_W-1:0] c_slice [NREQ];

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_slice
    assign a_slice[gi] = req_a[gi*DATA_W +: DATA_W];
    assign b_slice[gi] = req_b[gi*DATA_W +: DATA_W];
    assign c_slice[gi] = req_ctrl[gi*CTRL_W +: CTRL_W];
  end

  // Grants are only offered in IDLE and never while reset is held.
  assign arb_enable = (state_reg == IDLE) && !reset;

  rr_arbiter #(
    .NREQ  (NREQ),
    .IDX_W (IDX_W)
  ) u_rr (
    .req    (req_valid),
    .ptr    (ptr_reg),
    .enable (arb_enable),
    .grant  (grant),
    .idx    (grant_idx)
  );

  assign accept   = |grant;
  assign rsp_fire = rsp_ready[owner_reg];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg     <= IDLE;
      ptr_reg       <= '0;
      owner_reg     <= '0;
      lat_cnt_reg   <= '0;
      rsp_valid_reg <= '0;
      rsp_r_reg     <= '0;
      rsp_zero_reg  <= 1'b0;
      alu_a_reg     <= '0;
      alu_b_reg     <= '0;
      alu_ctrl_reg  <= '0;
      ops_done_reg  <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (accept) begin
            alu_a_reg    <= a_slice[grant_idx];
            alu_b_reg    <= b_slice[grant_idx];
            alu_ctrl_reg <= c_slice[grant_idx];
            owner_reg    <= grant_idx;
            ptr_reg      <= (grant_idx == IDX_W'(NREQ - 1)) ? '0 : grant_idx + IDX_W'(1);
            lat_cnt_reg  <= LAT_W'(ALU_LAT);
            state_reg    <= EXEC;
          end
        end
        EXEC: begin
          if (lat_cnt_reg == '0) begin
            rsp_r_reg     <= alu_r;
            rsp_zero_reg  <= alu_zero;
            rsp_valid_reg <= NREQ'(1) << owner_reg;
            state_reg     <= RESP;
          end else begin
            lat_cnt_reg <= lat_cnt_reg - LAT_W'(1);
          end
        end
        RESP: begin
          if (rsp_fire) begin
            rsp_valid_reg <= '0;
            ops_done_reg  <= ops_done_reg + CNT_W'(1);
            state_reg     <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign req_ready = grant;
  assign rsp_valid = rsp_valid_reg;
  assign rsp_r     = rsp_r_reg;
  assign rsp_zero  = rsp_zero_reg;
  assign alu_a     = alu_a_reg;
  assign alu_b     = alu_b_reg;
  assign alu_ctrl  = alu_ctrl_reg;
  assign busy      = (state_reg != IDLE);
  assign ops_done  = ops_done_reg;
endmodule

// File: tb/tb_alu_issue_arbiter.sv
// Bench for alu_issue_arbiter: two configurations, each with an adder ALU stub and a cycle model.
module tb_alu_issue_arbiter;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input int cfg, input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL cfg%0d %s: got %0h expected %0h at %0t", cfg, name, act, exp, $time);
    end
  endtask

  for (genvar gi = 0; gi < 2; gi++) begin : g_cfg
    localparam int LAT = (gi == 0) ? 1 : 3;
    localparam int CW  = (gi == 0) ? 16 : 4;

    logic        reset;
    logic [1:0]  req_valid, req_ready, rsp_valid, rsp_ready;
    logic [31:0] req_a, req_b;
    logic [5:0]  req_ctrl;
    logic [15:0] rsp_r, alu_a, alu_b, alu_r, alu_sum;
    logic [2:0]  alu_ctrl;
    logic        rsp_zero, alu_zero, busy;
    logic [CW-1:0] ops_done;
    logic [16:0] pipe [LAT];
    bit          done = 1'b0;

    alu_issue_arbiter #(
      .NREQ(2), .DATA_W(16), .CTRL_W(3), .ALU_LAT(LAT), .CNT_W(CW)
    ) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_a(req_a), .req_b(req_b), .req_ctrl(req_ctrl),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_r(rsp_r), .rsp_zero(rsp_zero),
      .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
      .alu_r(alu_r), .alu_zero(alu_zero),
      .busy(busy), .ops_done(ops_done)
    );

    // ALU stub: R = A + B after LAT register stages.
    assign alu_sum = alu_a + alu_b;
    always @(posedge clk) begin
      pipe[0] <= {alu_sum == 16'h0000, alu_sum};
      for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end
    assign alu_r    = pipe[LAT-1][15:0];
    assign alu_zero = pipe[LAT-1][16];

    task automatic step();
      @(posedge clk);
      #1;
    endtask

    // Transaction-level model: one op in flight, response due LAT+2 cycles after accept.
    int cyc = 0, acc_cyc = 0, own = 0, ptr = 0, ops = 0;
    bit inflt = 1'b0;
    logic [15:0] ma = '0, mb = '0;
    logic [2:0]  mc = '0;

    always @(negedge clk) begin : model
      int g;
      bit due;
      logic [15:0] sum;
      logic [1:0]  rv_exp;
      g      = -1;
      due    = inflt && (cyc - acc_cyc >= LAT + 2);
      sum    = ma + mb;
      rv_exp = due ? 2'(1 << own) : 2'b00;
      if (reset) begin
        chk(gi, "rst_ctl", {ops_done != 0, busy, rsp_zero, req_ready, rsp_valid}, 0);
        chk(gi, "rst_data", {rsp_r, alu_ctrl, alu_a, alu_b}, 0);
        inflt = 1'b0; ptr = 0; ops = 0; own = 0;
        ma = '0; mb = '0; mc = '0;
      end else begin
        if (!inflt)
          for (int k = 0; k < 2; k++)
            if (g < 0 && req_valid[(ptr + k) % 2]) g = (ptr + k) % 2;
        chk(gi, "req_ready", req_ready, (g >= 0) ? 2'(1 << g) : 2'b00);
        chk(gi, "rsp_valid", rsp_valid, rv_exp);
        if (due) begin
          chk(gi, "rsp_r", rsp_r, sum);
          chk(gi, "rsp_zero", rsp_zero, sum == 16'h0000);
        end
        chk(gi, "alu_in", {alu_ctrl, alu_a, alu_b}, {mc, ma, mb});
        chk(gi, "busy", busy, inflt);
        chk(gi, "ops_done", ops_done, ops % (1 << CW));
        if (g >= 0) begin
          inflt   = 1'b1;
          acc_cyc = cyc;
          own     = g;
          ma      = req_a[g*16 +: 16];
          mb      = req_b[g*16 +: 16];
          mc      = req_ctrl[g*3 +: 3];
          ptr     = (g + 1) % 2;
        end else if (due && rsp_ready[own]) begin
          inflt = 1'b0;
          ops++;
          $display("cfg%0d op %0d: owner=%0d a=%h b=%h r=%h", gi, ops, own, ma, mb, sum);
        end
      end
      cyc++;
    end

    if (gi == 0) begin : g_stim
      initial begin
        int n;
        reset = 1'b1; req_valid = '0; req_a = '0; req_b = '0; req_ctrl = '0; rsp_ready = '0;
        step(); step();
        reset = 1'b0;
        #1;
        chk(0, "rst_req_ready", req_ready, 2'b00);
        chk(0, "rst_busy", busy, 1'b0);
        step();
        // Single op on requester 0.
        req_a[15:0] = 16'h0003; req_b[15:0] = 16'h0004; req_ctrl[2:0] = 3'd1;
        req_valid = 2'b01; rsp_ready = 2'b01;
        #1;
        chk(0, "single_grant", req_ready, 2'b01);
        step(); req_valid = 2'b00;
        chk(0, "single_alu_a", alu_a, 16'h0003);
        step();
        chk(0, "single_early", rsp_valid, 2'b00);
        step();
        chk(0, "single_rsp_valid", rsp_valid, 2'b01);
        chk(0, "single_rsp_r", rsp_r, 16'h0007);
        chk(0, "single_rsp_zero", rsp_zero, 1'b0);
        step();
        chk(0, "single_ops_done", ops_done, 16'd1);
        // Backpressure on requester 1; non-owner ready must be ignored.
        req_a[31:16] = 16'h0005; req_b[31:16] = 16'h0006; req_ctrl[5:3] = 3'd2;
        req_valid = 2'b10; rsp_ready = 2'b01;
        #1;
        chk(0, "bp_grant", req_ready, 2'b10);
        step(); req_valid = 2'b01;
        step(); step();
        chk(0, "bp_rsp_valid", rsp_valid, 2'b10);
        for (int i = 0; i < 5; i++) begin
          chk(0, "bp_hold_r", rsp_r, 16'h000B);
          chk(0, "bp_hold_busy", busy, 1'b1);
          chk(0, "bp_hold_ready", req_ready, 2'b00);
          step();
        end
        rsp_ready = 2'b10;
        chk(0, "bp_still_valid", rsp_valid, 2'b10);
        step();
        chk(0, "bp_ops_done", ops_done, 16'd2);
        chk(0, "bp_next_grant", req_ready, 2'b01);
        rsp_ready = 2'b11;
        step(); step(); step();
        chk(0, "bp_req0_r", rsp_r, 16'h0007);
        step();
        // Contention from reset: grants must alternate 0,1,0,1.
        reset = 1'b1; req_valid = 2'b11;
        req_a = {16'hFFFF, 16'h0001}; req_b = {16'h0001, 16'h0002}; req_ctrl = '0;
        step();
        reset = 1'b0;
        #1;
        for (int k = 0; k < 4; k++) begin
          n = 0;
          while (req_ready == 2'b00 && n < 8) begin step(); n++; end
          chk(0, "cont_grant", req_ready, (k % 2 == 0) ? 2'b01 : 2'b10);
          n = 0;
          while (rsp_valid == 2'b00 && n < 8) begin step(); n++; end
          chk(0, "cont_r", rsp_r, (k % 2 == 0) ? 16'h0003 : 16'h0000);
          chk(0, "cont_zero", rsp_zero, (k % 2 == 1));
          step();
        end
        req_valid = 2'b00;
        #1;
        step(); step();
        // Reset in the middle of EXEC abandons the op.
        req_a[15:0] = 16'h0009; req_b[15:0] = 16'h0009; req_valid = 2'b01;
        #1;
        chk(0, "mid_grant", req_ready, 2'b01);
        step();
        reset = 1'b1;
        #1;
        chk(0, "mid_ops_done", ops_done, 16'd0);
        chk(0, "mid_rsp_valid", rsp_valid, 2'b00);
        step(); step();
        reset = 1'b0;
        #1;
        chk(0, "mid_regrant", req_ready, 2'b01);
        step(); req_valid = 2'b00;
        step(); step();
        chk(0, "mid_rsp_valid2", rsp_valid, 2'b01);
        chk(0, "mid_rsp_r", rsp_r, 16'h0012);
        step();
        chk(0, "mid_ops_after", ops_done, 16'd1);
        done = 1'b1;
      end
    end else begin : g_stim
      initial begin
        int n;
        reset = 1'b1; req_valid = '0; req_a = '0; req_b = '0; req_ctrl = '0; rsp_ready = 2'b01;
        step(); step();
        reset = 1'b0;
        req_a[15:0] = 16'h0000; req_b[15:0] = 16'h0001; req_valid = 2'b01;
        #1;
        for (int k = 0; k < 16; k++) begin
          n = 0;
          while (req_ready == 2'b00 && n < 10) begin step(); n++; end
          chk(1, "wrap_grant", req_ready, 2'b01);
          step();
          req_a[15:0] = 16'(k + 1);
          n = 1;
          while (rsp_valid == 2'b00 && n < 12) begin step(); n++; end
          chk(1, "wrap_latency", n, 5);
          chk(1, "wrap_r", rsp_r, 16'(k + 1));
          step();
        end
        req_valid = 2'b00;
        chk(1, "wrap_ops_done", ops_done, 4'd0);
        step();
        done = 1'b1;
      end
    end
  end

  initial begin
    int n;
    n = 0;
    while (!(g_cfg[0].done && g_cfg[1].done) && n < 5000) begin
      @(posedge clk);
      n++;
    end
    chk(-1, "finish", {g_cfg[0].done, g_cfg[1].done}, 2'b11);
    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
